// File: rtl/ncl_wavefront_sequencer.sv
// ncl_wavefront_sequencer: clocked four-phase driver for one NCL threshold-gate stage.
// Applies DATA/NULL wavefronts and returns the captured rail1 result over valid/ready.
module ncl_wavefront_sequencer #(
    parameter int IN_W        = 4,
    parameter int OUT_W       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [IN_W-1:0]  ncl_d1,
    output logic [IN_W-1:0]  ncl_d0,
    input  logic             ncl_ko,
    input  logic [OUT_W-1:0] ncl_z1,
    input  logic [OUT_W-1:0] ncl_z0,
    output logic             ncl_ki,
    input  logic             clr_err,
    output logic             err_timeout,
    output logic             err_illegal
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA_WAIT,
        NULL_WAIT,
        HOLD,
        ERROR
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0]            ko_sync_q, ko_sync_d;
    logic [SYNC_STAGES-1:0][OUT_W-1:0] z1_sync_q, z1_sync_d;
    logic [SYNC_STAGES-1:0][OUT_W-1:0] z0_sync_q, z0_sync_d;

    logic [IN_W-1:0]  d1_q, d1_d, d0_q, d0_d;
    logic             ki_q, ki_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             err_to_q, err_to_d;
    logic             err_il_q, err_il_d;

    logic             ko_s;
    logic [OUT_W-1:0] z1_s, z0_s;
    logic             out_complete, out_null, illegal, timer_hit;

    assign ko_s = ko_sync_q[SYNC_STAGES-1];
    assign z1_s = z1_sync_q[SYNC_STAGES-1];
    assign z0_s = z0_sync_q[SYNC_STAGES-1];

    assign out_complete = &(z1_s ^ z0_s);
    assign out_null     = ~|(z1_s | z0_s);
    assign illegal      = |(z1_s & z0_s);
    assign timer_hit    = (timer_q == TW'(TIMEOUT - 1));

    assign in_ready    = (state_q == IDLE) & ko_s & ~out_valid_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign ncl_d1      = d1_q;
    assign ncl_d0      = d0_q;
    assign ncl_ki      = ki_q;
    assign err_timeout = err_to_q;
    assign err_illegal = err_il_q;

    always_comb begin
        ko_sync_d = {ko_sync_q[SYNC_STAGES-2:0], ncl_ko};
        z1_sync_d = {z1_sync_q[SYNC_STAGES-2:0], ncl_z1};
        z0_sync_d = {z0_sync_q[SYNC_STAGES-2:0], ncl_z0};
    end

    always_comb begin
        state_d     = state_q;
        d1_d        = d1_q;
        d0_d        = d0_q;
        ki_d        = ki_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        timer_d     = timer_q;
        err_to_d    = clr_err ? 1'b0 : err_to_q;
        err_il_d    = clr_err ? 1'b0 : err_il_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    d1_d    = in_data;
                    d0_d    = ~in_data;
                    timer_d = '0;
                    state_d = DATA_WAIT;
                end
            end
            DATA_WAIT: begin
                if (!ko_s && out_complete) begin
                    out_data_d = z1_s;
                    d1_d       = '0;
                    d0_d       = '0;
                    ki_d       = 1'b0;
                    timer_d    = '0;
                    state_d    = NULL_WAIT;
                end else if (timer_hit) begin
                    err_to_d = 1'b1;
                    state_d  = ERROR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            NULL_WAIT: begin
                if (ko_s && out_null) begin
                    ki_d        = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else if (timer_hit) begin
                    err_to_d = 1'b1;
                    state_d  = ERROR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            ERROR: begin
                if (clr_err && ko_s && out_null) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // a dual-high output bit overrides any completion or timeout this cycle
        if (illegal && state_q != ERROR) begin
            err_il_d   = 1'b1;
            out_data_d = out_data_q;
            timer_d    = timer_q;
            state_d    = ERROR;
        end

        if (state_d == ERROR) begin
            d1_d        = '0;
            d0_d        = '0;
            ki_d        = 1'b1;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ko_sync_q   <= '0;
            z1_sync_q   <= '0;
            z0_sync_q   <= '0;
            d1_q        <= '0;
            d0_q        <= '0;
            ki_q        <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            timer_q     <= '0;
            err_to_q    <= 1'b0;
            err_il_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ko_sync_q   <= ko_sync_d;
            z1_sync_q   <= z1_sync_d;
            z0_sync_q   <= z0_sync_d;
            d1_q        <= d1_d;
            d0_q        <= d0_d;
            ki_q        <= ki_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            timer_q     <= timer_d;
            err_to_q    <= err_to_d;
            err_il_q    <= err_il_d;
        end
    end

endmodule

// File: tb/tb_ncl_wavefront_sequencer.sv
// tb_ncl_wavefront_sequencer: directed + random checks of the NCL wavefront sequencer
// against a delayed AND/OR dual-rail stage stub and a queue-based result model.
module tb_ncl_wavefront_sequencer;
    localparam int DLY = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_ready, out_valid, ncl_ko, ncl_ki, err_timeout, err_illegal;
    logic [3:0] ncl_d1, ncl_d0;
    logic [1:0] out_data, ncl_z1, ncl_z0;

    logic       ko_hi = 1'b0;
    logic       ko_lo = 1'b0;
    logic       inj = 1'b0;
    logic [4:0] pipe [DLY];
    logic [4:0] tgt;
    logic [1:0] q [$];

    int total = 0;
    int passed = 0;
    int fails = 0;

    ncl_wavefront_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ncl_d1(ncl_d1), .ncl_d0(ncl_d0), .ncl_ko(ncl_ko),
        .ncl_z1(ncl_z1), .ncl_z0(ncl_z0), .ncl_ki(ncl_ki),
        .clr_err(clr_err), .err_timeout(err_timeout), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] fz(input logic [3:0] d);
        return {d[2] | d[3], d[0] & d[1]};
    endfunction

    // stage stub: full DATA -> result and ko=0, full NULL -> NULL and ko=1
    always_comb begin
        tgt = pipe[0];
        if ((ncl_d1 ^ ncl_d0) == 4'hF) tgt = {1'b0, fz(ncl_d1), ~fz(ncl_d1)};
        else if ((ncl_d1 | ncl_d0) == 4'h0) tgt = 5'b10000;
    end

    initial foreach (pipe[i]) pipe[i] = 5'b10000;

    always @(posedge clk) begin
        pipe[0] <= tgt;
        for (int i = 1; i < DLY; i++) pipe[i] <= pipe[i-1];
    end

    assign ncl_ko = ko_hi | (~ko_lo & pipe[DLY-1][4]);
    assign ncl_z1 = pipe[DLY-1][3:2] | {1'b0, inj};
    assign ncl_z0 = pipe[DLY-1][1:0] | {1'b0, inj};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_data = v;
        while (!in_ready && n < 300) begin tick(); n++; end
        chk("send_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        q.push_back(fz(v));
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 300) begin tick(); n++; end
        chk("wait_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic recv();
        logic [1:0] e;
        wait_valid();
        e = (q.size() != 0) ? q.pop_front() : 2'bxx;
        chk("out_data", 32'(out_data), 32'(e));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    task automatic stream(input int nvec, input bit rnd);
        int sent = 0;
        int got = 0;
        int n = 0;
        bit acc, dlv, stall;
        logic rails_ok;
        logic [3:0] cur;
        logic [1:0] held, e;
        cur = 4'($urandom);
        stall = 1'b0;
        held = 2'b00;
        while (got < nvec && n < 4000) begin
            in_valid = (sent < nvec) && (!rnd || $urandom_range(0, 1) == 1);
            in_data = cur;
            out_ready = !rnd || $urandom_range(0, 3) != 0;
            rails_ok = ((ncl_d1 & ncl_d0) == 4'h0) &&
                       ((ncl_d1 | ncl_d0) == 4'h0 || (ncl_d1 | ncl_d0) == 4'hF);
            chk("excl", 32'(in_ready & out_valid), 32'd0);
            chk("rails", 32'(rails_ok), 32'd1);
            if (stall) chk("hold", 32'({out_valid, out_data}), 32'({1'b1, held}));
            acc = in_valid && in_ready;
            dlv = out_valid && out_ready;
            if (dlv) begin
                e = (q.size() != 0) ? q.pop_front() : 2'bxx;
                chk("stream_data", 32'(out_data), 32'(e));
                got++;
            end
            stall = out_valid && !out_ready;
            held = out_data;
            if (acc) begin
                q.push_back(fz(cur));
                sent++;
                cur = 4'($urandom);
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("stream_count", 32'(got), 32'(nvec));
    endtask

    initial begin
        logic [1:0] held;
        int n;

        #12;
        chk("rst_d1", 32'(ncl_d1), 32'd0);
        chk("rst_d0", 32'(ncl_d0), 32'd0);
        chk("rst_ki", 32'(ncl_ki), 32'd1);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_od", 32'(out_data), 32'd0);
        chk("rst_err", 32'({err_timeout, err_illegal}), 32'd0);
        chk("rst_ir", 32'(in_ready), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("ir_sync1", 32'(in_ready), 32'd0);
        tick();
        chk("ir_sync2", 32'(in_ready), 32'd1);

        send(4'b1011);
        chk("data_d1", 32'(ncl_d1), 32'hB);
        chk("data_d0", 32'(ncl_d0), 32'h4);
        chk("data_ki", 32'(ncl_ki), 32'd1);
        n = 0;
        while (ncl_ki && n < 100) begin tick(); n++; end
        chk("ki_low", 32'(ncl_ki), 32'd0);
        chk("null_rails", 32'({ncl_d1, ncl_d0}), 32'd0);
        wait_valid();
        chk("ki_high", 32'(ncl_ki), 32'd1);
        recv();

        stream(3, 1'b0);

        send(4'($urandom));
        wait_valid();
        held = out_data;
        repeat (20) begin
            tick();
            chk("bp_hold", 32'({out_valid, out_data, in_ready}), 32'({1'b1, held, 1'b0}));
        end
        recv();
        chk("bp_idle", 32'(in_ready), 32'd1);
        send(4'($urandom));
        recv();

        stream(20, 1'b1);

        ko_hi = 1'b1;
        send(4'($urandom));
        q.delete();
        repeat (63) tick();
        chk("tmo_early", 32'(err_timeout), 32'd0);
        tick();
        chk("tmo_set", 32'(err_timeout), 32'd1);
        chk("tmo_rails", 32'({ncl_d1, ncl_d0, ncl_ki, out_valid}), 32'h002);
        repeat (10) tick();
        chk("tmo_noready", 32'(in_ready), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("tmo_clr", 32'(err_timeout), 32'd0);
        chk("tmo_idle", 32'(in_ready), 32'd1);
        ko_hi = 1'b0;

        send(4'($urandom));
        q.delete();
        inj = 1'b1;
        tick();
        tick();
        chk("ill_early", 32'(err_illegal), 32'd0);
        tick();
        chk("ill_set", 32'(err_illegal), 32'd1);
        chk("ill_ov", 32'(out_valid), 32'd0);
        chk("ill_rails", 32'({ncl_d1, ncl_d0}), 32'd0);
        inj = 1'b0;
        repeat (15) tick();
        chk("ill_noready", 32'(in_ready), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ill_clr", 32'(err_illegal), 32'd0);
        chk("ill_idle", 32'(in_ready), 32'd1);

        send(4'($urandom));
        q.delete();
        n = 0;
        while (ncl_ki && n < 100) begin tick(); n++; end
        chk("ar_nullwait", 32'(ncl_ki), 32'd0);
        ko_lo = 1'b1;
        #3;
        rst_n = 1'b0;
        #2;
        chk("ar_rails", 32'({ncl_d1, ncl_d0}), 32'd0);
        chk("ar_ki", 32'(ncl_ki), 32'd1);
        chk("ar_ov", 32'({out_valid, in_ready}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (8) tick();
        chk("ar_noko", 32'(in_ready), 32'd0);
        ko_lo = 1'b0;
        tick();
        chk("ar_sync1", 32'(in_ready), 32'd0);
        tick();
        chk("ar_sync2", 32'(in_ready), 32'd1);
        send(4'($urandom));
        recv();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
